seq_shift_unit: RTL and testbench

//  Multi-cycle barrel-shift replacement for the R-type datapath: shifts a WIDTH-bit operand
//  by 0..WIDTH-1 positions, one bit per clock, by recirculating a single 1-bit shift step.

---
 rtl/proc_alu_pkg.sv | 17 +
 rtl/shift_step1.sv | 23 ++
 rtl/seq_shift_unit.sv | 98 +++++++++
 tb/tb_seq_shift_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/proc_alu_pkg.sv
// Shared ALU package: shifter state encoding, width defaults
// and shift-direction constants.
package proc_alu_pkg;

    localparam int WIDTH_D = 32;
    localparam int SHW_D   = 5;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step1.sv
// Combinational single-position shift step.
// Ports: din (operand), dir (0 right / 1 left), arith (sign-fill on right), dout.
module shift_step1
    import proc_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_D
) (
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic             arith,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = '0;
        if (dir == DIR_LEFT) begin
            dout = {din[WIDTH-2:0], 1'b0};
        end else begin
            dout = {arith & din[WIDTH-1], din[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Sequential shifter: SLL/SRL/SRA at one bit per clock.
// Ports: clk, rst_n, start, A, shamt, dir, arith -> busy, done, result.
module seq_shift_unit
    import proc_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int SHW   = SHW_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t           state_q;
    state_t           state_d;
    logic [SHW-1:0]   count_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] step_out;
    logic             dir_q;
    logic             arith_q;

    shift_step1 #(
        .WIDTH (WIDTH)
    ) u_step (
        .din   (work_q),
        .dir   (dir_q),
        .arith (arith_q),
        .dout  (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (count_q == '0) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured only on accept, so start pulses
    // while busy cannot disturb an operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            work_q  <= '0;
            dir_q   <= DIR_RIGHT;
            arith_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q  <= A;
                        count_q <= shamt;
                        dir_q   <= dir;
                        arith_q <= arith;
                    end
                end
                SHIFT: begin
                    if (count_q != '0) begin
                        work_q  <= step_out;
                        count_q <= count_q - SHW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = work_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: vector table
// plus hand-written start-hammer and mid-op reset sequences.
module tb_seq_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [4:0]  shamt;
    logic        dir;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;

    seq_shift_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .shamt  (shamt),
        .dir    (dir),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic        dir;
        logic        ar;
        logic [31:0] exp;
    } vec_t;

    vec_t v[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op and wait for done (bounded). lat counts edges
    // from the accept edge (inclusive) to the first done sample.
    task automatic run_op(input logic [31:0] a, input logic [4:0] sh,
                          input logic d, input logic ar,
                          output int lat, output int bcnt);
        @(negedge clk);
        A = a; shamt = sh; dir = d; arith = ar; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 32'hX; shamt = 5'hX; dir = 1'bX; arith = 1'bX;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int ndone;
        checks = 0;
        errors = 0;
        start = 1'b0; A = '0; shamt = '0; dir = 1'b0; arith = 1'b0;
        rst_n = 1'b0;

        v[0] = '{32'hF000_0000, 5'd4,  1'b0, 1'b0, 32'h0F00_0000};
        v[1] = '{32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF};
        v[2] = '{32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000};
        v[3] = '{32'h0000_0001, 5'd31, 1'b1, 1'b1, 32'h8000_0000};
        v[4] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF};
        v[5] = '{32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001};
        v[6] = '{32'h0F00_0000, 5'd4,  1'b0, 1'b1, 32'h00F0_0000};
        v[7] = '{32'h1234_5678, 5'd8,  1'b1, 1'b0, 32'h3456_7800};
        v[8] = '{32'h8765_4321, 5'd8,  1'b0, 1'b1, 32'hFF87_6543};
        v[9] = '{32'h8765_4321, 5'd8,  1'b0, 1'b0, 32'h0087_6543};

        #12;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(v[i].a, v[i].sh, v[i].dir, v[i].ar, lat, bcnt);
            chk($sformatf("vec%0d_result", i), result, v[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 32'(v[i].sh) + 32'd2);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt,
                32'(v[i].sh) + 32'd1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_idle_busy", i), {31'b0, busy}, 32'd0);
            chk($sformatf("vec%0d_idle_done", i), {31'b0, done}, 32'd0);
            chk($sformatf("vec%0d_hold", i), result, v[i].exp);
        end

        // start held high through an SRL by 8; operands change
        // every cycle but must not affect the op in flight.
        @(negedge clk);
        A = 32'h1234_5678; shamt = 5'd8; dir = 1'b0; arith = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        A = 32'hFFFF_FFFF; shamt = 5'd3; dir = 1'b1; arith = 1'b1;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hammer_result", result, 32'h0012_3456);
        chk("hammer_latency", lat, 32'd10);
        @(posedge clk); #1;
        chk("hammer_idle_after_done", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("hammer_reaccept", {31'b0, busy}, 32'd1);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hammer_second_result", result, 32'hFFFF_FFF8);
        chk("hammer_second_latency", lat, 32'd5);

        // Reset pulse in the middle of an SRA by 20.
        @(posedge clk); #1;
        @(negedge clk);
        A = 32'h8000_0000; shamt = 5'd20; dir = 1'b0; arith = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);
        run_op(32'h8000_0000, 5'd20, 1'b0, 1'b1, lat, bcnt);
        chk("after_abort_result", result, 32'hFFFF_F800);
        chk("after_abort_latency", lat, 32'd22);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
